// File: rtl/edge_pkg.sv
// Shared state encodings for the edge_moore / pulse_stretch family.
// Encoding 2'd3 is unused and steers back to idle on the next edge.
package edge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HIGH = ST_HIGH,
        S_GAP  = ST_GAP
    } state_e;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter that saturates at zero; zero flag is decoded from the register.
module hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretch_moore.sv
// Tick-to-level stretcher: one ticc strobe gives a level pulse of HOLD cycles,
// followed by a forced low gap of GAP cycles. Ignored ticks raise dropped for a cycle.
// Build option: PULSE_STRETCH_RETRIGGER_EN lets a tick during HIGH restart the hold time.
//
// state   | meaning
// IDLE    | waiting for ticc, level=0, busy=0
// HIGH    | driving level for HOLD cycles, busy=1
// GAP     | forced low time before the next tick is accepted, busy=1
module pulse_stretch_moore
    import edge_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic ticc,
    output logic level,
    output logic busy,
    output logic dropped
);

    localparam int MAXV = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = ($clog2(MAXV + 1) > 1) ? $clog2(MAXV + 1) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG_EN = 1'b1;
`else
    localparam bit RETRIG_EN = 1'b0;
`endif

    state_e        state_q;
    state_e        state_d;
    logic          dropped_q;
    logic          dropped_d;
    logic          cnt_load;
    logic [CW-1:0] cnt_ld_val;
    logic          cnt_dec;
    logic          cnt_zero;

    hold_counter #(
        .W (CW)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state, counter control and dropped-flag decision.
    always_comb begin
        state_d    = state_q;
        dropped_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ticc) begin
                    state_d    = S_HIGH;
                    cnt_load   = 1'b1;
                    cnt_ld_val = HOLD_LD;
                end
            end
            S_HIGH: begin
                if (RETRIG_EN && ticc) begin
                    cnt_load   = 1'b1;
                    cnt_ld_val = HOLD_LD;
                end else begin
                    dropped_d = ticc;
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (GAP > 0) begin
                        state_d    = S_GAP;
                        cnt_load   = 1'b1;
                        cnt_ld_val = GAP_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                dropped_d = ticc;
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Unused encoding: the tick cannot be honoured, return to idle.
                dropped_d = ticc;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and dropped-flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dropped_q <= dropped_d;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        level   = (state_q == S_HIGH);
        busy    = (state_q != S_IDLE);
        dropped = dropped_q;
    end

endmodule

// File: tb/tb_pulse_stretch_moore.sv
// Bench for pulse_stretch_moore: four instances with different HOLD/GAP,
// a timestamp-based reference model, a spec vector table and corner sequences.
module tb_pulse_stretch_moore;

    localparam int NUM = 4;
    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 8;
    localparam int G1 = 1;
    localparam int H2 = 1;
    localparam int G2 = 0;
    localparam int H3 = 65535;
    localparam int G3 = 0;

`ifdef PULSE_STRETCH_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef struct {
        logic rst;
        logic tic;
        logic l;
        logic b;
        logic d;
    } vec_t;

    logic       clk = 1'b0;
    logic [3:0] rst_v;
    logic [3:0] tic_v;
    logic [3:0] lvl;
    logic [3:0] bsy;
    logic [3:0] drp;

    int hold_p[NUM] = '{H0, H1, H2, H3};
    int gap_p[NUM]  = '{G0, G1, G2, G3};
    int hi_end[NUM];
    int busy_end[NUM];
    logic m_drop[NUM];
    int edge_n;
    int checks;
    int failures;

    always #5 clk = ~clk;

    pulse_stretch_moore #(.HOLD(H0), .GAP(G0)) dut0 (
        .clk(clk), .reset(rst_v[0]), .ticc(tic_v[0]),
        .level(lvl[0]), .busy(bsy[0]), .dropped(drp[0]));
    pulse_stretch_moore #(.HOLD(H1), .GAP(G1)) dut1 (
        .clk(clk), .reset(rst_v[1]), .ticc(tic_v[1]),
        .level(lvl[1]), .busy(bsy[1]), .dropped(drp[1]));
    pulse_stretch_moore #(.HOLD(H2), .GAP(G2)) dut2 (
        .clk(clk), .reset(rst_v[2]), .ticc(tic_v[2]),
        .level(lvl[2]), .busy(bsy[2]), .dropped(drp[2]));
    pulse_stretch_moore #(.HOLD(H3), .GAP(G3)) dut3 (
        .clk(clk), .reset(rst_v[3]), .ticc(tic_v[3]),
        .level(lvl[3]), .busy(bsy[3]), .dropped(drp[3]));

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: a pulse accepted at edge k keeps level high after edges k..k+HOLD-1
    // and busy high after edges k..k+HOLD+GAP-1. Ticks are judged against those windows.
    task automatic model_edge(input logic [3:0] r, input logic [3:0] t);
        int e;
        e = edge_n;
        for (int i = 0; i < NUM; i++) begin
            m_drop[i] = 1'b0;
            if (!r[i]) begin
                hi_end[i]   = e;
                busy_end[i] = e;
            end else if (t[i]) begin
                if (e > busy_end[i]) begin
                    hi_end[i]   = e + hold_p[i];
                    busy_end[i] = e + hold_p[i] + gap_p[i];
                end else if (e <= hi_end[i] && RETRIG) begin
                    hi_end[i]   = e + hold_p[i];
                    busy_end[i] = e + hold_p[i] + gap_p[i];
                end else begin
                    m_drop[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] t);
        rst_v = r;
        tic_v = t;
        @(posedge clk);
        edge_n++;
        model_edge(r, t);
        #1;
        for (int i = 0; i < NUM; i++) begin
            chk($sformatf("model d%0d level", i), lvl[i], edge_n < hi_end[i]);
            chk($sformatf("model d%0d busy", i), bsy[i], edge_n < busy_end[i]);
            chk($sformatf("model d%0d dropped", i), drp[i], m_drop[i]);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        logic [3:0] r;
        logic [3:0] t;
        int hc;

        rst_v    = 4'b0000;
        tic_v    = 4'b0000;
        edge_n   = 0;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < NUM; i++) begin
            hi_end[i]   = 0;
            busy_end[i] = 0;
            m_drop[i]   = 1'b0;
        end

        // Reset, single tick at edge 5, tick inside gap at 10, accepted tick at 11 (HOLD=4, GAP=1).
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step({4{tbl[i].rst}}, {4{tbl[i].tic}});
            chk($sformatf("tbl[%0d] level", i), lvl[0], tbl[i].l);
            chk($sformatf("tbl[%0d] busy", i), bsy[0], tbl[i].b);
            chk($sformatf("tbl[%0d] dropped", i), drp[0], tbl[i].d);
        end

        step(4'b0000, 4'b0000);
        step(4'b1111, 4'b0000);

        // Second tick two edges into HIGH on HOLD=4.
        for (int j = 0; j < 8; j++) begin
            t = (j == 0 || j == 2) ? 4'b0001 : 4'b0000;
            step(4'b1111, t);
            chk($sformatf("retrig j%0d level", j), lvl[0], RETRIG ? (j <= 5) : (j <= 3));
            chk($sformatf("retrig j%0d dropped", j), drp[0], RETRIG ? 1'b0 : (j == 2));
        end
        for (int j = 0; j < 6; j++) step(4'b1111, 4'b0000);

        // HOLD=1, GAP=0 with a tick on every edge.
        for (int j = 0; j < 8; j++) begin
            step(4'b1111, 4'b0100);
            chk($sformatf("gap0 j%0d level", j), lvl[2], RETRIG ? 1'b1 : (j % 2 == 0));
            chk($sformatf("gap0 j%0d dropped", j), drp[2], RETRIG ? 1'b0 : (j % 2 == 1));
        end
        for (int j = 0; j < 3; j++) step(4'b1111, 4'b0000);

        // Reset mid-pulse on HOLD=8, with a tick asserted alongside reset.
        step(4'b1111, 4'b0010);
        chk("rstmid level e0", lvl[1], 1'b1);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        chk("rstmid level e2", lvl[1], 1'b1);
        step(4'b1101, 4'b0010);
        chk("rstmid level e3", lvl[1], 1'b0);
        chk("rstmid busy e3", bsy[1], 1'b0);
        chk("rstmid dropped e3", drp[1], 1'b0);
        step(4'b1111, 4'b0000);
        chk("rstmid level e4", lvl[1], 1'b0);
        chk("rstmid busy e4", bsy[1], 1'b0);
        step(4'b1111, 4'b0010);
        chk("rstmid relaunch level", lvl[1], 1'b1);
        for (int j = 0; j < 12; j++) step(4'b1111, 4'b0000);

        // Random ticks and occasional resets against the model.
        for (int j = 0; j < 3000; j++) begin
            for (int i = 0; i < NUM; i++) begin
                r[i] = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                t[i] = ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0;
            end
            step(r, t);
        end

        // Full-width hold: HOLD=65535 must not wrap.
        step(4'b0000, 4'b0000);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b1000);
        hc = lvl[3] ? 1 : 0;
        for (int j = 0; j < 65540; j++) begin
            step(4'b1111, 4'b0000);
            if (lvl[3]) hc++;
        end
        chk_int("wide hold cycles", hc, 65535);
        chk("wide level end", lvl[3], 1'b0);
        chk("wide busy end", bsy[3], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
